// File: rtl/reg_bank_sp_gen.sv
// General-purpose register file with hardwired zero register, bounded stack pointer,
// registered read ports with optional write bypass, and an answer-register tap.
module reg_bank_sp_gen #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned SP_RESET = 16,
  parameter int unsigned SP_STEP  = 1,
  parameter int unsigned SP_MIN   = 0,
  parameter int unsigned SP_MAX   = 16,
  parameter int unsigned ANS_REG  = 15,
  parameter int unsigned BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [1:0]        sp_op,
  input  logic [DATA_W-1:0] sp_wdata,
  input  logic              clr_flags,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic [DATA_W-1:0] rd_sp,
  output logic [DATA_W-1:0] answer_out,
  output logic              sp_ovf,
  output logic              sp_udf
);

  // One extra bit so SP bound comparisons cannot wrap.
  localparam int unsigned EXT_W = DATA_W + 1;

  localparam logic [1:0] SP_LOAD = 2'b01;
  localparam logic [1:0] SP_PUSH = 2'b10;
  localparam logic [1:0] SP_POP  = 2'b11;

  localparam logic [EXT_W-1:0]  PUSH_FLOOR = EXT_W'(SP_MIN) + EXT_W'(SP_STEP);
  localparam logic [EXT_W-1:0]  POP_CEIL   = EXT_W'(SP_MAX);
  localparam logic [EXT_W-1:0]  STEP_EXT   = EXT_W'(SP_STEP);
  localparam logic [DATA_W-1:0] STEP_VAL   = DATA_W'(SP_STEP);
  localparam logic [DATA_W-1:0] SP_RST_VAL = DATA_W'(SP_RESET);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [DATA_W-1:0] sp_q, sp_d;
  logic              sp_ovf_q, sp_ovf_d;
  logic              sp_udf_q, sp_udf_d;
  logic [DATA_W-1:0] rd_data1_q, rd_data1_d;
  logic [DATA_W-1:0] rd_data2_q, rd_data2_d;
  logic [DATA_W-1:0] rd_sp_q, rd_sp_d;
  logic [DATA_W-1:0] answer_q, answer_d;
  logic [EXT_W-1:0]  sp_ext;

  // Register writes; index 0 and out-of-range addresses never match a slot.
  always_comb begin
    regs_d    = regs_q;
    regs_d[0] = '0;
    if (wr_en) begin
      for (int unsigned i = 1; i < NUM_REGS; i++) begin
        if (wr_addr == ADDR_W'(i)) regs_d[i] = wr_data;
      end
    end
  end

  // Read muxes: bypass selects the post-write view of the array.
  always_comb begin
    rd_data1_d = '0;
    rd_data2_d = '0;
    answer_d   = '0;
    for (int unsigned i = 1; i < NUM_REGS; i++) begin
      if (rd_addr1 == ADDR_W'(i)) rd_data1_d = (BYPASS != 0) ? regs_d[i] : regs_q[i];
      if (rd_addr2 == ADDR_W'(i)) rd_data2_d = (BYPASS != 0) ? regs_d[i] : regs_q[i];
      if (ANS_REG == i)           answer_d   = regs_d[i];
    end
  end

  // Stack pointer with bound checks; a rejected op sets its flag over a clear.
  always_comb begin
    sp_ext   = {1'b0, sp_q};
    sp_d     = sp_q;
    sp_ovf_d = clr_flags ? 1'b0 : sp_ovf_q;
    sp_udf_d = clr_flags ? 1'b0 : sp_udf_q;
    case (sp_op)
      SP_LOAD: sp_d = sp_wdata;
      SP_PUSH: begin
        if (sp_ext >= PUSH_FLOOR) sp_d = sp_q - STEP_VAL;
        else                      sp_ovf_d = 1'b1;
      end
      SP_POP: begin
        if (sp_ext + STEP_EXT <= POP_CEIL) sp_d = sp_q + STEP_VAL;
        else                               sp_udf_d = 1'b1;
      end
      default: ;
    endcase
    rd_sp_d = sp_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      sp_q       <= SP_RST_VAL;
      sp_ovf_q   <= 1'b0;
      sp_udf_q   <= 1'b0;
      rd_data1_q <= '0;
      rd_data2_q <= '0;
      rd_sp_q    <= SP_RST_VAL;
      answer_q   <= '0;
    end else begin
      regs_q     <= regs_d;
      sp_q       <= sp_d;
      sp_ovf_q   <= sp_ovf_d;
      sp_udf_q   <= sp_udf_d;
      rd_data1_q <= rd_data1_d;
      rd_data2_q <= rd_data2_d;
      rd_sp_q    <= rd_sp_d;
      answer_q   <= answer_d;
    end
  end

  assign rd_data1   = rd_data1_q;
  assign rd_data2   = rd_data2_q;
  assign rd_sp      = rd_sp_q;
  assign answer_out = answer_q;
  assign sp_ovf     = sp_ovf_q;
  assign sp_udf     = sp_udf_q;

endmodule

// File: tb/tb_reg_bank_sp_gen.sv
// Directed bench for reg_bank_sp_gen: behavioural model checked every cycle plus literal pins.
module tb_reg_bank_sp_gen;

  localparam int unsigned BYP = 1;

  logic        clk;
  logic        rst;
  logic [4:0]  rd_addr1, rd_addr2, wr_addr;
  logic        wr_en;
  logic [31:0] wr_data;
  logic [1:0]  sp_op;
  logic [31:0] sp_wdata;
  logic        clr_flags;
  logic [31:0] rd_data1, rd_data2, rd_sp, answer_out;
  logic        sp_ovf, sp_udf;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 0;

  // Model state
  logic [31:0] m_regs [16];
  longint      m_sp;
  bit          m_ovf, m_udf;
  logic [31:0] e_rd1, e_rd2, e_sp, e_ans;

  reg_bank_sp_gen #(.BYPASS(BYP)) dut (
    .clk(clk), .rst(rst),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .sp_op(sp_op), .sp_wdata(sp_wdata), .clr_flags(clr_flags),
    .rd_data1(rd_data1), .rd_data2(rd_data2), .rd_sp(rd_sp),
    .answer_out(answer_out), .sp_ovf(sp_ovf), .sp_udf(sp_udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 0 || a >= 16) return 32'h0;
    if (BYP != 0 && wr_en && wr_addr == a) return wr_data;
    return m_regs[a];
  endfunction

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    if (rst) begin
      for (int i = 0; i < 16; i++) m_regs[i] = 32'h0;
      m_sp = 16; m_ovf = 0; m_udf = 0;
      e_rd1 = 0; e_rd2 = 0;
    end else begin
      e_rd1 = m_read(rd_addr1);
      e_rd2 = m_read(rd_addr2);
      if (wr_en && wr_addr != 0 && wr_addr < 16) m_regs[wr_addr] = wr_data;
      if (clr_flags) begin m_ovf = 0; m_udf = 0; end
      case (sp_op)
        2'b01: m_sp = longint'(sp_wdata);
        2'b10: if (m_sp >= 0 + 1) m_sp = m_sp - 1; else m_ovf = 1;
        2'b11: if (m_sp + 1 <= 16) m_sp = m_sp + 1; else m_udf = 1;
        default: ;
      endcase
    end
    e_sp  = 32'(m_sp);
    e_ans = m_regs[15];
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    rst = 0; wr_en = 0; wr_addr = 0; wr_data = 0;
    rd_addr1 = 0; rd_addr2 = 0; sp_op = 2'b00; sp_wdata = 0; clr_flags = 0;
  endtask

  // Cycle-by-cycle comparison against the model.
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      check("rd_data1", rd_data1, e_rd1);
      check("rd_data2", rd_data2, e_rd2);
      check("rd_sp", rd_sp, e_sp);
      check("answer_out", answer_out, e_ans);
      check("sp_ovf", 32'(sp_ovf), 32'(m_ovf));
      check("sp_udf", 32'(sp_udf), 32'(m_udf));
    end
  end

  initial begin
    idle_inputs();
    // Reset held two cycles with a write pending
    rst = 1; wr_en = 1; wr_addr = 3; wr_data = 32'hAA;
    chk_en = 1;
    cycle(); cycle();
    check("lit_reset_rd1", rd_data1, 32'h0);
    check("lit_reset_sp", rd_sp, 32'd16);
    check("lit_reset_flags", 32'({sp_ovf, sp_udf}), 32'h0);
    idle_inputs(); rd_addr1 = 3;
    cycle();
    check("lit_r3_after_reset", rd_data1, 32'h0);

    // Write/read and zero register
    wr_en = 1; wr_addr = 5; wr_data = 32'h1234; cycle();
    wr_addr = 0; wr_data = 32'hFFFF; cycle();
    wr_addr = 20; wr_data = 32'hBEEF; cycle();
    wr_en = 0; rd_addr1 = 5; rd_addr2 = 0; cycle();
    check("lit_r5", rd_data1, 32'h1234);
    check("lit_r0", rd_data2, 32'h0);
    rd_addr1 = 20; rd_addr2 = 5; cycle();
    check("lit_r20", rd_data1, 32'h0);

    // Bypass: old 0x11, same-cycle write 0x55 on both ports
    wr_en = 1; wr_addr = 7; wr_data = 32'h11; rd_addr1 = 0; rd_addr2 = 0; cycle();
    wr_data = 32'h55; rd_addr1 = 7; rd_addr2 = 7; cycle();
    check("lit_bypass_p1", rd_data1, 32'h55);
    check("lit_bypass_p2", rd_data2, 32'h55);
    wr_en = 0; cycle();

    // SP bounds
    sp_op = 2'b11;
    for (int i = 0; i < 16; i++) cycle();
    check("lit_pop_sp", rd_sp, 32'd16);
    check("lit_pop_udf", 32'(sp_udf), 32'd1);
    sp_op = 2'b10;
    for (int i = 0; i < 16; i++) cycle();
    check("lit_push_sp", rd_sp, 32'd0);
    cycle();
    check("lit_push_min_sp", rd_sp, 32'd0);
    check("lit_push_ovf", 32'(sp_ovf), 32'd1);
    sp_op = 2'b00; clr_flags = 1; cycle();
    check("lit_clr", 32'({sp_ovf, sp_udf}), 32'h0);
    sp_op = 2'b10; cycle();
    check("lit_set_wins", 32'(sp_ovf), 32'd1);
    clr_flags = 0;

    // Answer tap with concurrent SP load
    wr_en = 1; wr_addr = 15; wr_data = 32'd42; sp_op = 2'b01; sp_wdata = 32'd100; cycle();
    check("lit_answer", answer_out, 32'd42);
    check("lit_load_sp", rd_sp, 32'd100);
    wr_en = 0; sp_op = 2'b10; cycle();
    check("lit_push_100", rd_sp, 32'd99);

    // Mixed traffic over all addresses
    for (int i = 0; i < 24; i++) begin
      wr_en = (i % 3) != 2; wr_addr = 5'(i); wr_data = 32'(i) * 32'h01010101;
      rd_addr1 = 5'((i + 31) % 32); rd_addr2 = 5'(i);
      sp_op = 2'((i % 4)); sp_wdata = 32'(i + 10);
      cycle();
    end

    // Mid-sequence reset with a write to the answer register and a push pending
    rst = 1; wr_en = 1; wr_addr = 15; wr_data = 32'd7; sp_op = 2'b10; cycle();
    check("lit_midreset_ans", answer_out, 32'h0);
    check("lit_midreset_sp", rd_sp, 32'd16);
    idle_inputs(); rd_addr1 = 15; cycle();
    check("lit_midreset_r15", rd_data1, 32'h0);

    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_bank_sp_gen.md
Name: reg_bank_sp_gen

Overview:
Parametrised general-purpose register file for the single-cycle and multi-cycle processor datapaths. It has two registered read ports, one write port and a hardwired zero register. A dedicated stack-pointer register supports load, push and pop, with bound checking and sticky fault flags. Registered read-after-write bypass and a registered debug/answer tap are provided. It replaces the fixed 32-bit, 16-register bank.

Parameters:
DATA_W, 32, width of every register and data port.
NUM_REGS, 16, number of general registers; index 0 reads as zero.
ADDR_W, 5, register address width; must satisfy 2**ADDR_W >= NUM_REGS.
SP_RESET, 16, stack-pointer value after reset.
SP_STEP, 1, amount SP changes on each push or pop.
SP_MIN, 0, lowest legal SP value (stack grows downward).
SP_MAX, 16, highest legal SP value.
ANS_REG, 15, index of the register mirrored on answer_out.
BYPASS, 1, 1 = same-cycle write is visible on read ports; 0 = reads return the pre-write value.

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, synchronous, active-high
rd_addr1  in  ADDR_W  read port 1 address
rd_addr2  in  ADDR_W  read port 2 address
wr_en  in  1  general register write enable
wr_addr  in  ADDR_W  general register write address
wr_data  in  DATA_W  general register write data
sp_op  in  2  00 hold, 01 load, 10 push (SP -= SP_STEP), 11 pop (SP += SP_STEP)
sp_wdata  in  DATA_W  SP load value
clr_flags  in  1  clears sp_ovf and sp_udf
rd_data1  out  DATA_W  registered read data, port 1
rd_data2  out  DATA_W  registered read data, port 2
rd_sp  out  DATA_W  registered SP value
answer_out  out  DATA_W  registered copy of register ANS_REG
sp_ovf  out  1  sticky: a push was rejected below SP_MIN
sp_udf  out  1  sticky: a pop was rejected above SP_MAX

Behaviour:
- Reset (rst=1 at an edge):
  - registers 1..NUM_REGS-1 become 0; SP becomes SP_RESET.
  - rd_data1, rd_data2, answer_out, sp_ovf and sp_udf become 0.
  - rd_sp becomes SP_RESET.
  - Reset overrides every other input in that cycle, including a write or SP op in progress.
- Read latency is 1 cycle: outputs at edge N+1 reflect the addresses sampled at edge N.
- Zero register:
  - Writes to address 0 are discarded; reads of 0 return 0.
  - Addresses >= NUM_REGS: writes are discarded, reads return 0.
- Write: when wr_en=1 and the address is legal and nonzero, the register is updated at the edge.
- Bypass, when wr_en=1 and rd_addrX==wr_addr (legal, nonzero):
  - BYPASS=1: rd_dataX captures wr_data.
  - BYPASS=0: rd_dataX captures the old register content.
- SP operations, all unsigned DATA_W arithmetic, no wrap-around:
  - load: SP = sp_wdata unconditionally; no bounds check; flags unaffected.
  - push: if SP >= SP_MIN + SP_STEP, SP -= SP_STEP; else SP is unchanged and sp_ovf is set.
  - pop: if SP + SP_STEP <= SP_MAX (compared without overflow), SP += SP_STEP; else SP is unchanged and sp_udf is set.
- rd_sp shows the post-operation SP one cycle after the op, independent of BYPASS.
- answer_out captures the post-write value of register ANS_REG. A write to ANS_REG appears on answer_out at the same edge the register updates.
- Flags:
  - Flags stay set until clr_flags=1 or reset.
  - If a set event and clr_flags occur in the same cycle, set wins.
- Simultaneous events:
  - General write and SP op in the same cycle are independent and both take effect.
  - Both read ports at the same address return identical data.
- State: registers array, SP register, two flag bits, four output registers. No FSM beyond the SP bound logic.

Test Plan:
- Reset: assert rst for 2 cycles with wr_en=1, wr_addr=3, wr_data=0xAA -> all rd outputs 0, rd_sp=16, flags 0; reg 3 reads 0 afterwards.
- Write/read and zero: write 0x1234 to r5, then write 0xFFFF to r0; read r5/r0 -> 0x1234 and 0 one cycle after the address is applied.
- Bypass: same-cycle wr r7=0x55 and rd_addr1=7 (old value 0x11) -> rd_data1=0x55 with BYPASS=1, 0x11 with BYPASS=0.
- SP bounds at defaults:
  - 16 pops from reset -> SP stays 16 and sp_udf=1.
  - Then 16 pushes -> SP=0.
  - One more push -> SP stays 0 and sp_ovf=1.
  - clr_flags -> both flags 0.
- Flag priority: clr_flags=1 in the same cycle as a rejected push -> sp_ovf=1.
- Answer tap and concurrency:
  - Write r15=42 together with sp_op=load 100 -> answer_out=42 and rd_sp=100 at the next edge.
  - A mid-sequence reset -> answer_out=0 and rd_sp=16.
